// File: rtl/hazard_scoreboard_pkg.sv
//==============================================================================
// Module : hazard_scoreboard_pkg
// Desc   : Shared types and forwarding helpers for the ID-stage hazard scoreboard
// Rev    : 1.0
//==============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_DIV  = 2'b11
  } lat_class_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Widest supported age field; entries zero-extend their local age into it.
  localparam int SB_AGE_W = 8;

  typedef struct packed {
    logic [SB_AGE_W-1:0] age;
    logic [1:0]          rdy;
  } sb_entry_t;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_regWrite;
    logic [4:0] id_rd;
    logic [1:0] id_class;
    logic       id_flush;
    logic       ex_kill;
  } sb_in_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  forwA;
    logic [1:0]  forwB;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;
  } sb_out_t;

  function automatic logic [1:0] fwd_sel(input sb_entry_t e);
    if (e.age == SB_AGE_W'(2))      return FWD_EXMEM;
    else if (e.age == SB_AGE_W'(1)) return FWD_MEMWB;
    else                            return FWD_RF;
  endfunction

  function automatic logic src_hazard(input sb_entry_t e);
    return e.age > SB_AGE_W'(e.rdy);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_sb_entry.sv
//==============================================================================
// Module : sb_entry
// Desc   : One scoreboard slot: result age and forwardable-from point
// Rev    : 1.0
//==============================================================================
`default_nettype none

module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int AGE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [AGE_W-1:0] load_age,
  input  logic [1:0]       load_rdy,
  input  logic             kill,
  output sb_entry_t        entry
);

  logic [AGE_W-1:0] r_age;
  logic [1:0]       r_rdy;

  // A new writer owns the slot even when a kill targets it in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_age <= '0;
      r_rdy <= '0;
    end else if (load) begin
      r_age <= load_age;
      r_rdy <= load_rdy;
    end else if (kill) begin
      r_age <= '0;
    end else if (r_age != '0) begin
      r_age <= r_age - AGE_W'(1);
    end
  end

  assign entry.age = SB_AGE_W'(r_age);
  assign entry.rdy = r_rdy;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
//==============================================================================
// Module : hazard_scoreboard
// Desc   : ID-stage stall/forwarding unit with per-register result scoreboard
// Rev    : 1.0
//==============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_regWrite,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic [1:0]          id_class,
  input  logic                id_flush,
  input  logic                ex_kill,
  output logic                stall,
  output logic [1:0]          forwA,
  output logic [1:0]          forwB,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_age_w   = $clog2(c_max_lat + 2);

  lat_class_e         w_cls;
  logic [c_age_w-1:0] w_a0;
  logic [c_age_w-1:0] w_hold_ld;
  logic [1:0]         w_rdy_ld;
  logic               w_issue, w_wr, w_kill;
  logic               w_chk1, w_chk2, w_haz1, w_haz2;
  sb_entry_t          w_entry [NUM_REGS];
  sb_entry_t          w_src1, w_src2;

  logic [c_age_w-1:0] r_ex_hold;
  logic               r_last_valid;
  logic [REG_AW-1:0]  r_last_rd;
  lat_class_e         r_last_class;
  logic [CNT_W-1:0]   r_stall_cnt;

  assign w_cls = lat_class_e'(id_class);

  always_comb begin
    w_a0      = c_age_w'(2);
    w_rdy_ld  = 2'd2;
    w_hold_ld = '0;
    case (w_cls)
      CLS_LOAD: w_rdy_ld = 2'd1;
      CLS_MUL: begin
        w_a0      = c_age_w'(MUL_LAT + 1);
        w_hold_ld = c_age_w'(MUL_LAT - 1);
      end
      CLS_DIV: begin
        w_a0      = c_age_w'(DIV_LAT + 1);
        w_hold_ld = c_age_w'(DIV_LAT - 1);
      end
      default: ;
    endcase
  end

  assign w_src1 = w_entry[id_rs1];
  assign w_src2 = w_entry[id_rs2];
  assign w_chk1 = id_use_rs1 & (id_rs1 != '0);
  assign w_chk2 = id_use_rs2 & (id_rs2 != '0);
  assign w_haz1 = w_chk1 & src_hazard(w_src1);
  assign w_haz2 = w_chk2 & src_hazard(w_src2);
  assign forwA  = w_chk1 ? fwd_sel(w_src1) : FWD_RF;
  assign forwB  = w_chk2 ? fwd_sel(w_src2) : FWD_RF;

  assign stall   = id_valid & (w_haz1 | w_haz2 | (r_ex_hold != '0));
  assign w_issue = id_valid & ~stall & ~id_flush;
  assign w_wr    = w_issue & id_regWrite & (id_rd != '0);
  assign w_kill  = ex_kill & r_last_valid;

  assign w_entry[0]  = '0;
  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(
      .AGE_W(c_age_w)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .load    (w_wr & (id_rd == REG_AW'(r))),
      .load_age(w_a0),
      .load_rdy(w_rdy_ld),
      .kill    (w_kill & (r_last_rd == REG_AW'(r))),
      .entry   (w_entry[r])
    );
    assign busy_vec[r] = (w_entry[r].age != '0);
  end

  // Issue only happens with ex_hold already at zero, so issue may simply reload it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_hold    <= '0;
      r_last_valid <= 1'b0;
      r_last_rd    <= '0;
      r_last_class <= CLS_ALU;
      r_stall_cnt  <= '0;
    end else begin
      if (w_issue)
        r_ex_hold <= w_hold_ld;
      else if (w_kill && (r_last_class == CLS_MUL || r_last_class == CLS_DIV))
        r_ex_hold <= '0;
      else if (r_ex_hold != '0)
        r_ex_hold <= r_ex_hold - c_age_w'(1);

      r_last_valid <= w_issue;
      r_last_rd    <= id_regWrite ? id_rd : '0;
      r_last_class <= w_cls;

      if (stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
